// File: rtl/tx_word_feeder.sv
// Buffers NB_WORD-bit words in a small FIFO and feeds them to the UART tx LSB byte first.
// Pop-to-start latency 1 cycle; o_ready drops when the FIFO is full (writes then dropped, o_overflow).
module tx_word_feeder #(
  parameter int NB_DATA    = 8,
  parameter int NB_WORD    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_valid,
  input  logic [NB_WORD-1:0]            i_word,
  output logic                          o_ready,
  input  logic                          i_done_tx,
  output logic                          o_tx_start,
  output logic [NB_DATA-1:0]            o_data,
  output logic                          o_busy,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int BYTES = NB_WORD / NB_DATA;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int BW    = $clog2(BYTES);

  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_SEND = 3'b010;
  localparam logic [2:0] ST_WAIT = 3'b100;

  logic [2:0]          state_q, state_d;
  logic [NB_WORD-1:0]  mem_q [FIFO_DEPTH];
  logic [NB_WORD-1:0]  mem_d [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [NB_WORD-1:0]  shreg_q, shreg_d;
  logic [BW-1:0]       byte_cnt_q, byte_cnt_d;
  logic                overflow_q, overflow_d;
  logic                push, pop;

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    shreg_d    = shreg_q;
    byte_cnt_d = byte_cnt_q;
    overflow_d = overflow_q;

    push = i_valid && (count_q != CW'(FIFO_DEPTH));
    pop  = state_q[0] && (count_q != '0);

    if (push) begin
      mem_d[wr_ptr_q] = i_word;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (i_valid && !push) begin
      overflow_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // Simultaneous push and pop leave the occupancy unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          shreg_d    = mem_q[rd_ptr_q];
          byte_cnt_d = '0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_done_tx) begin
          if (byte_cnt_q == BW'(BYTES - 1)) begin
            state_d = ST_IDLE;
          end else begin
            shreg_d    = shreg_q >> NB_DATA;
            byte_cnt_d = byte_cnt_q + BW'(1);
            state_d    = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shreg_q    <= '0;
      byte_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shreg_q    <= shreg_d;
      byte_cnt_q <= byte_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_ready    = (count_q != CW'(FIFO_DEPTH));
  assign o_tx_start = state_q[1];
  assign o_data     = shreg_q[NB_DATA-1:0];
  assign o_busy     = !state_q[0] || (count_q != '0);
  assign o_overflow = overflow_q;
  assign o_count    = count_q;

endmodule

// File: tb/tb_tx_word_feeder.sv
// Bench for tx_word_feeder: word-level reference model, byte scoreboard, and a tx stand-in
// that answers every o_tx_start with a done pulse 20 cycles later.
module tb_tx_word_feeder;
  localparam int DEPTH = 4;
  localparam int BYTES = 4;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_word = '0;
  logic        i_done_tx;
  logic        o_ready, o_tx_start, o_busy, o_overflow;
  logic [7:0]  o_data;
  logic [2:0]  o_count;

  logic tx_done = 1'b0;
  logic extra_done = 1'b0;
  assign i_done_tx = tx_done | extra_done;

  tx_word_feeder #(.NB_DATA(8), .NB_WORD(32), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_word(i_word), .o_ready(o_ready),
    .i_done_tx(i_done_tx), .o_tx_start(o_tx_start), .o_data(o_data), .o_busy(o_busy),
    .o_overflow(o_overflow), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words waiting, the word being sent and which byte of it is on the wire.
  typedef enum {M_IDLE, M_SEND, M_WAIT} mst_t;
  logic [31:0] mq[$];
  logic [7:0]  exp_bytes[$];
  mst_t        m_st = M_IDLE;
  logic [31:0] m_word = '0;
  int          m_byte = 0;
  bit          m_over = 1'b0;

  initial forever begin
    bit acc;
    @(posedge i_clk);
    if (!i_rst) begin
      mq.delete();
      exp_bytes.delete();
      m_st = M_IDLE; m_word = '0; m_byte = 0; m_over = 1'b0;
    end else begin
      acc = i_valid && (mq.size() != DEPTH);
      if (i_valid && !acc) m_over = 1'b1;
      case (m_st)
        M_IDLE: if (mq.size() != 0) begin
          m_word = mq.pop_front(); m_byte = 0; m_st = M_SEND;
        end
        M_SEND: m_st = M_WAIT;
        M_WAIT: if (i_done_tx) begin
          if (m_byte == BYTES - 1) m_st = M_IDLE;
          else begin m_byte++; m_st = M_SEND; end
        end
      endcase
      if (acc) begin
        mq.push_back(i_word);
        for (int b = 0; b < BYTES; b++) exp_bytes.push_back(i_word[8*b +: 8]);
      end
    end
  end

  // tx stand-in: done pulse 20 cycles after each start pulse.
  initial begin
    int tx_timer;
    tx_timer = 0;
    forever begin
      @(negedge i_clk);
      tx_done = 1'b0;
      if (tx_timer > 0) begin
        tx_timer--;
        if (tx_timer == 0) tx_done = 1'b1;
      end
      if (o_tx_start === 1'b1) tx_timer = 20;
    end
  end

  // Monitor: every cycle compare outputs to the model; every start pulse pops the scoreboard.
  initial forever begin
    @(negedge i_clk);
    if (chk_en) begin
      check("o_ready", o_ready, mq.size() != DEPTH);
      check("o_count", o_count, mq.size());
      check("o_busy", o_busy, (m_st != M_IDLE) || (mq.size() != 0));
      check("o_overflow", o_overflow, m_over);
      check("o_tx_start", o_tx_start, m_st == M_SEND);
      check("o_data", o_data, m_word[8*m_byte +: 8]);
      if (o_tx_start === 1'b1) begin
        if (exp_bytes.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_byte: start pulse with byte %0h, expected no pulse", o_data);
        end else begin
          check("tx_byte", o_data, exp_bytes.pop_front());
        end
      end
    end
  end

  task automatic wr(input logic [31:0] w);
    i_valid = 1'b1; i_word = w;
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_st != M_IDLE || mq.size() != 0) && n < 5000) begin
      @(negedge i_clk); n++;
    end
    repeat (2) @(negedge i_clk);
    check("idle_busy", o_busy, 1'b0);
  endtask

  // qsz/byt < 0 mean "don't care".
  task automatic wait_for(input mst_t st, input int qsz, input int byt);
    int n = 0;
    while (!(m_st == st && (qsz < 0 || mq.size() == qsz) && (byt < 0 || m_byte == byt))
           && n < 5000) begin
      @(negedge i_clk); n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL wait_for: state %0d not reached, model in %0d", st, m_st);
    end
  endtask

  initial begin
    repeat (2) @(negedge i_clk);
    chk_en = 1'b1;
    @(negedge i_clk);
    check("rst_ready", o_ready, 1'b1);
    check("rst_count", o_count, 3'd0);
    i_rst = 1'b1;
    @(negedge i_clk);

    // Single word, LSB byte first.
    wr(32'hDDCCBBAA);
    wait_idle();

    // Five back-to-back words plus one dropped while full.
    for (int i = 0; i < 5; i++) wr($urandom);
    check("t2_count_full", o_count, 3'd4);
    check("t2_ready_full", o_ready, 1'b0);
    wr(32'h0BAD0BAD);
    check("t2_overflow", o_overflow, 1'b1);
    wait_idle();

    // Push coinciding with the IDLE pop at count 1.
    wr($urandom); wr($urandom);
    wait_for(M_WAIT, -1, -1);
    wait_for(M_IDLE, 1, -1);
    wr(32'h13572468);
    check("t3_count", o_count, 3'd1);
    wait_idle();

    // Reset during WAIT of the second byte.
    wr(32'h44332211);
    wait_for(M_WAIT, -1, 1);
    i_rst = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    check("t4_overflow", o_overflow, 1'b0);
    check("t4_busy", o_busy, 1'b0);
    check("t4_data", o_data, 8'h00);
    repeat (25) @(negedge i_clk);
    wr(32'h88776655);
    wait_idle();

    // Done pulses in IDLE and SEND are ignored.
    extra_done = 1'b1; @(negedge i_clk); extra_done = 1'b0;
    repeat (3) @(negedge i_clk);
    wr(32'hCAFEF00D);
    wait_for(M_SEND, -1, -1);
    extra_done = 1'b1; @(negedge i_clk); extra_done = 1'b0;
    wait_idle();

    // Twelve words, pointers wrap; write whenever the model says there is room.
    for (int i = 0; i < 12; i++) begin
      int n = 0;
      while (mq.size() == DEPTH && n < 5000) begin @(negedge i_clk); n++; end
      wr($urandom);
      if ($urandom_range(0, 3) == 0) @(negedge i_clk);
    end
    wait_idle();

    // Random valid traffic, including writes while full.
    for (int i = 0; i < 60; i++) begin
      i_valid = ($urandom_range(0, 9) < 3);
      i_word  = $urandom;
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    wait_idle();

    check("end_scoreboard_empty", exp_bytes.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
